ps2_keycode_rx: RTL
===================

// Module: ps2_keycode_rx
// PURPOSE
//  Receives PS/2 keyboard frames and decodes set-2 make/break/extended prefixes into a held keycode.
//  Produces the 8-bit keycode bus consumed by the game-state and ball-motion logic.
//  keycode holds the code of the last pressed key; it returns to 0x00 when that key is released.
//  Sits between the keyboard pins and the game top level, all in the Clk domain.
// PARAMETERS
//  FILTER_LEN   8       consecutive identical Clk samples needed to accept a ps2_clk level change
//  TIMEOUT_CYC  50000   Clk cycles without a ps2_clk falling edge that abort a partial frame (1 ms @ 50 MHz)
// PORTS
//  Clk         in   1  system clock, 50 MHz
//  Reset       in   1  asynchronous, active-low reset
//  ps2_clk     in   1  keyboard clock pin, asynchronous, 10-16.7 kHz
//  ps2_data    in   1  keyboard data pin, asynchronous
//  keycode     out  8  scan code of the currently held key; 0x00 = none held
//  extended    out  1  1 when the held key was prefixed by 0xE0
//  key_event   out  1  1-cycle pulse whenever keycode/extended is updated
//  key_break   out  1  qualifies key_event: 1 = release, 0 = press
//  scan_byte   out  8  last correctly received raw byte
//  scan_valid  out  1  1-cycle pulse when scan_byte is updated
//  frame_err   out  1  1-cycle pulse on parity, stop or timeout error
// BEHAVIOUR
//  Reset: all outputs 0, FSM = IDLE, prefix flags cleared, filter and timeout counters cleared.
//  Input conditioning:
//   - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
//   - filt_clk changes only after FILTER_LEN equal synced samples (reset value 1).
//   - A fall = filt_clk 1->0. data_s is the synced ps2_data, sampled in the same cycle as the fall.
//  Frame FSM (advances only on a fall):
//   - IDLE: data_s == 0 -> DATA with bit_cnt = 0. data_s == 1 -> stay IDLE, no error.
//   - DATA: shift data_s in LSB first. After the 8th bit -> PARITY.
//   - PARITY: store data_s -> STOP.
//   - STOP: if data_s == 1 and the 9 bits (data + parity) have odd parity, pulse scan_valid
//     on the next Clk cycle with the new scan_byte. Otherwise pulse frame_err. Either way -> IDLE.
//  Timeout:
//   - A counter is cleared on every fall and counts while the FSM is not IDLE.
//   - When it reaches TIMEOUT_CYC: FSM -> IDLE and frame_err pulses.
//   - The partial byte is discarded; scan_byte is unchanged.
//  Decoder (acts in the cycle scan_valid is high; outputs registered, so key_event is 1 cycle after scan_valid):
//   - 0xE0: set ext_pend. No key_event.
//   - 0xF0: set brk_pend. No key_event.
//   - Any other byte B, brk_pend = 0: keycode <= B, extended <= ext_pend, key_event = 1, key_break = 0.
//   - Any other byte B, brk_pend = 1: key_event = 1, key_break = 1. If B == keycode and
//     ext_pend == extended, keycode <= 0 and extended <= 0; otherwise keycode is unchanged.
//   - ext_pend and brk_pend are cleared after any non-prefix byte.
//   - Typematic repeats of the held make code re-pulse key_event with identical keycode.
//  On frame_err: ext_pend and brk_pend are cleared (resynchronise); keycode is held.
//  Pulses (scan_valid, key_event, frame_err) are exactly 1 Clk wide. They never overlap within one frame.
//  Reset asserted mid-frame: immediate return to reset values. The next frame starts cleanly at its start bit.
// TESTING
//  1. Send frame 0x1D (W: start 0, 10111000, parity 1, stop 1) -> scan_valid with scan_byte = 0x1D;
//     next cycle key_event = 1, key_break = 0, keycode = 0x1D, extended = 0.
//  2. After 1, send 0xF0 then 0x1D -> one key_event with key_break = 1; keycode = 0x00.
//     Sending 0xF0, 0x1C instead leaves keycode = 0x1D.
//  3. Send 0xE0, 0x75 then 0xE0, 0xF0, 0x75 -> keycode = 0x75 with extended = 1, then 0x00 with extended = 0.
//  4. Send 0x1D with the parity bit flipped, then 0x1D with stop = 0 -> two frame_err pulses;
//     no scan_valid and no key_event; keycode unchanged.
//  5. Stop ps2_clk after 5 data bits for TIMEOUT_CYC + 10 cycles -> one frame_err; FSM = IDLE;
//     a following good 0x1C frame yields keycode = 0x1C.
//  6. Inject a 4-cycle low glitch on ps2_clk while idle, and assert Reset mid-frame
//     -> the glitch causes no state change; the reset clears all outputs; the next frame decodes correctly.

Source files
------------

// File: rtl/ps2_keycode_rx.sv
// PS/2 set-2 keyboard receiver: filters the pins, deframes bytes, and tracks the held key
// (make / break / 0xE0-extended) as an 8-bit keycode.
module ps2_keycode_rx #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       extended,
  output logic       key_event,
  output logic       key_break,
  output logic [7:0] scan_byte,
  output logic       scan_valid,
  output logic       frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  logic [1:0]    clk_sync_q, dat_sync_q;
  logic          clk_s, data_s;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall;
  state_e        state_q, state_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_q, to_d;
  logic          sv_q, sv_d, err_q, err_d;
  logic [7:0]    sbyte_q, sbyte_d;
  logic [7:0]    kc_q, kc_d;
  logic          ext_q, ext_d, kev_q, kev_d, kbrk_q, kbrk_d;
  logic          ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;

  assign clk_s  = clk_sync_q[1];
  assign data_s = dat_sync_q[1];

  // A ps2_clk level change is only accepted after FILTER_LEN consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall   = 1'b0;
    if (clk_s != filt_q) begin
      if (fcnt_q == FW'(FILTER_LEN - 1)) begin
        filt_d = clk_s;
        fall   = filt_q;
      end else begin
        fcnt_d = fcnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    to_d    = to_q;
    sbyte_d = sbyte_q;
    sv_d    = 1'b0;
    err_d   = 1'b0;
    if (fall) begin
      to_d = '0;
      case (state_q)
        IDLE: if (!data_s) begin
          state_d = DATA;
          bit_d   = '0;
        end
        DATA: begin
          shift_d = {data_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = data_s;
          state_d = STOP;
        end
        default: begin
          if (data_s && (^{shift_q, par_q})) begin
            sv_d    = 1'b1;
            sbyte_d = shift_q;
          end else begin
            err_d = 1'b1;
          end
          state_d = IDLE;
        end
      endcase
    end else if (state_q != IDLE) begin
      // Keyboard stalled mid-frame: drop the partial byte and resynchronise.
      if (to_q == TW'(TIMEOUT_CYC - 1)) begin
        state_d = IDLE;
        err_d   = 1'b1;
        to_d    = '0;
      end else begin
        to_d = to_q + 1'b1;
      end
    end else begin
      to_d = '0;
    end
  end

  always_comb begin
    kc_d       = kc_q;
    ext_d      = ext_q;
    kbrk_d     = kbrk_q;
    kev_d      = 1'b0;
    ext_pend_d = ext_pend_q;
    brk_pend_d = brk_pend_q;
    if (sv_q) begin
      case (sbyte_q)
        8'hE0: ext_pend_d = 1'b1;
        8'hF0: brk_pend_d = 1'b1;
        default: begin
          kev_d  = 1'b1;
          kbrk_d = brk_pend_q;
          if (!brk_pend_q) begin
            kc_d  = sbyte_q;
            ext_d = ext_pend_q;
          end else if (sbyte_q == kc_q && ext_pend_q == ext_q) begin
            kc_d  = 8'h00;
            ext_d = 1'b0;
          end
          ext_pend_d = 1'b0;
          brk_pend_d = 1'b0;
        end
      endcase
    end else if (err_q) begin
      ext_pend_d = 1'b0;
      brk_pend_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      clk_sync_q <= 2'b11;
      dat_sync_q <= 2'b11;
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= IDLE;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      to_q       <= '0;
      sv_q       <= 1'b0;
      err_q      <= 1'b0;
      sbyte_q    <= '0;
      kc_q       <= '0;
      ext_q      <= 1'b0;
      kev_q      <= 1'b0;
      kbrk_q     <= 1'b0;
      ext_pend_q <= 1'b0;
      brk_pend_q <= 1'b0;
    end else begin
      clk_sync_q <= {clk_sync_q[0], ps2_clk};
      dat_sync_q <= {dat_sync_q[0], ps2_data};
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      to_q       <= to_d;
      sv_q       <= sv_d;
      err_q      <= err_d;
      sbyte_q    <= sbyte_d;
      kc_q       <= kc_d;
      ext_q      <= ext_d;
      kev_q      <= kev_d;
      kbrk_q     <= kbrk_d;
      ext_pend_q <= ext_pend_d;
      brk_pend_q <= brk_pend_d;
    end
  end

  assign keycode    = kc_q;
  assign extended   = ext_q;
  assign key_event  = kev_q;
  assign key_break  = kbrk_q;
  assign scan_byte  = sbyte_q;
  assign scan_valid = sv_q;
  assign frame_err  = err_q;
endmodule
